// File: rtl/tictactoe_pkg.sv
// rtl/tictactoe_pkg.sv - shared board types and constants for the board arbiter
//
// Purpose: the cell encoding, the default board size, the arbiter state type
//          and a helper that range-checks a board address.
// Ports:   none (package).
package tictactoe_pkg;

  localparam int NCELLS_DEF = 9;
  localparam int ADDR_W     = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    X     = 2'b10,
    O     = 2'b11
  } cellStateType;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arbState;

  function automatic logic addr_valid(input logic [ADDR_W-1:0] addr, input int ncells);
    return int'(addr) < ncells;
  endfunction

endpackage

// File: rtl/board_clear_seq.sv
// rtl/board_clear_seq.sv - address counter that sweeps every board cell once
//
// Purpose: on start_i, walks addr_o through 0..NCELLS-1, one address per
//          cycle, then pulses done_o for one cycle.
// Ports:   clk_i     - clock (rising edge)
//          resetn_i  - synchronous active-low reset; aborts a sweep silently
//          start_i   - begin a sweep (ignored while one is running)
//          addr_o    - cell currently being wiped
//          last_o    - high during the cycle that wipes the final cell
//          done_o    - one-cycle pulse after the final cell
module board_clear_seq
  import tictactoe_pkg::*;
#(
  parameter int NCELLS = NCELLS_DEF
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              start_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o,
  output logic              done_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NCELLS - 1);

  logic [ADDR_W-1:0] cnt_q;
  logic              run_q;
  logic              done_q;

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (run_q) begin
        if (cnt_q == LAST_ADDR) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else if (start_i) begin
        cnt_q <= '0;
        run_q <= 1'b1;
      end
    end
  end

  assign addr_o = cnt_q;
  assign last_o = run_q && (cnt_q == LAST_ADDR);
  assign done_o = done_q;

endmodule

// File: rtl/board_arbiter.sv
// rtl/board_arbiter.sv - single-port board arbiter for writer, checker, display and wipe
//
// Purpose: shares one board port between a writer, two readers and a full-board
//          clear. Writes win over reads unless the writer has held the port for
//          WR_BURST_MAX grants while a read waits; the two readers alternate.
// Ports:   ph1, ph2            - phase clocks; all state moves on rising ph1
//          reset               - synchronous active-low reset
//          wrReq/wrAddr/wrData - write request
//          chkReq/chkAddr      - win-checker read request
//          dispReq/dispAddr    - display read request
//          clrReq              - start a board wipe
//          *Grant              - one-cycle grant pulses
//          rdData/chkValid/dispValid - read return, one cycle after the grant
//          clrDone/addrErr/busy      - status
//          memAddr/memWe/memWdata/memRdata - board port (async read)
module board_arbiter
  import tictactoe_pkg::*;
#(
  parameter int NCELLS       = NCELLS_DEF,
  parameter int WR_BURST_MAX = 3
) (
  input  logic              ph1,
  input  logic              ph2,
  input  logic              reset,
  input  logic              wrReq,
  input  logic [ADDR_W-1:0] wrAddr,
  input  cellStateType      wrData,
  input  logic              chkReq,
  input  logic [ADDR_W-1:0] chkAddr,
  input  logic              dispReq,
  input  logic [ADDR_W-1:0] dispAddr,
  input  logic              clrReq,
  output logic              wrGrant,
  output logic              chkGrant,
  output logic              dispGrant,
  output cellStateType      rdData,
  output logic              chkValid,
  output logic              dispValid,
  output logic              clrDone,
  output logic              addrErr,
  output logic              busy,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memWe,
  output cellStateType      memWdata,
  input  cellStateType      memRdata
);

  localparam logic [3:0] BURST = 4'(WR_BURST_MAX);

  logic ph2_unused;
  assign ph2_unused = ph2;

  arbState           state_q;
  logic              wrGrant_q, chkGrant_q, dispGrant_q;
  logic              chkValid_q, dispValid_q, addrErr_q, busy_q, memWe_q;
  logic [ADDR_W-1:0] memAddr_q;
  cellStateType      memWdata_q, rdData_q;
  logic [3:0]        streak_q;
  logic              rr_disp_q;   // 0: checker has precedence on a tie

  logic              clr_start, clr_last, clr_done;
  logic [ADDR_W-1:0] clr_addr;

  logic              any_grant, rd_pend, pick_wr, pick_chk, pick_disp;
  logic [ADDR_W-1:0] rd_addr;
  logic [3:0]        streak_d;

  always_comb begin
    any_grant = wrGrant_q | chkGrant_q | dispGrant_q;
    rd_pend   = chkReq | dispReq;
    pick_wr   = wrReq && !((streak_q == BURST) && rd_pend);
    pick_chk  = !pick_wr && chkReq && (!dispReq || !rr_disp_q);
    pick_disp = !pick_wr && dispReq && !pick_chk;
    rd_addr   = pick_chk ? chkAddr : dispAddr;
    streak_d  = (streak_q == BURST) ? BURST : streak_q + 4'd1;
  end

  assign clr_start = (state_q == IDLE) && clrReq;

  board_clear_seq #(.NCELLS(NCELLS)) u_clear (
    .clk_i    (ph1),
    .resetn_i (reset),
    .start_i  (clr_start),
    .addr_o   (clr_addr),
    .last_o   (clr_last),
    .done_o   (clr_done)
  );

  always_ff @(posedge ph1) begin
    if (!reset) begin
      state_q     <= IDLE;
      wrGrant_q   <= 1'b0;
      chkGrant_q  <= 1'b0;
      dispGrant_q <= 1'b0;
      chkValid_q  <= 1'b0;
      dispValid_q <= 1'b0;
      addrErr_q   <= 1'b0;
      busy_q      <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= EMPTY;
      rdData_q    <= EMPTY;
      streak_q    <= 4'd0;
      rr_disp_q   <= 1'b0;
    end else begin
      wrGrant_q   <= 1'b0;
      chkGrant_q  <= 1'b0;
      dispGrant_q <= 1'b0;
      chkValid_q  <= 1'b0;
      dispValid_q <= 1'b0;
      addrErr_q   <= 1'b0;

      // The read address is still on the port during the grant cycle, so the
      // async read data is captured at the end of it.
      if ((chkGrant_q || dispGrant_q) && !addrErr_q) begin
        chkValid_q  <= chkGrant_q;
        dispValid_q <= dispGrant_q;
        rdData_q    <= memRdata;
      end

      case (state_q)
        IDLE: begin
          memWe_q <= 1'b0;
          if (clrReq) begin
            state_q    <= CLEAR;
            busy_q     <= 1'b1;
            memWe_q    <= 1'b1;
            memWdata_q <= EMPTY;
            streak_q   <= 4'd0;
          end else if (!any_grant) begin
            // A grant cycle is a turnaround: requests seen during it are the
            // ones just served, so no new decision is made and the streak holds.
            if (pick_wr) begin
              wrGrant_q <= 1'b1;
              streak_q  <= streak_d;
              if (addr_valid(wrAddr, NCELLS)) begin
                memWe_q    <= 1'b1;
                memAddr_q  <= wrAddr;
                memWdata_q <= wrData;
              end else begin
                addrErr_q <= 1'b1;
                memAddr_q <= '0;
              end
            end else if (pick_chk || pick_disp) begin
              chkGrant_q  <= pick_chk;
              dispGrant_q <= pick_disp;
              rr_disp_q   <= ~rr_disp_q;
              streak_q    <= 4'd0;
              if (addr_valid(rd_addr, NCELLS)) begin
                memAddr_q <= rd_addr;
              end else begin
                addrErr_q <= 1'b1;
                memAddr_q <= '0;
              end
            end else begin
              streak_q <= 4'd0;
            end
          end
        end
        CLEAR: begin
          if (clr_last) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            memWe_q   <= 1'b0;
            memAddr_q <= clr_addr;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wrGrant   = wrGrant_q;
  assign chkGrant  = chkGrant_q;
  assign dispGrant = dispGrant_q;
  assign chkValid  = chkValid_q;
  assign dispValid = dispValid_q;
  assign rdData    = rdData_q;
  assign addrErr   = addrErr_q;
  assign busy      = busy_q;
  assign clrDone   = clr_done;
  assign memWe     = memWe_q;
  assign memWdata  = memWdata_q;
  // During a wipe the sweep counter owns the address lines.
  assign memAddr   = busy_q ? clr_addr : memAddr_q;

endmodule

// File: doc/board_arbiter.md
BOARD_ARBITER -- requirements
Module: board_arbiter

Interface
REQ-001 SHALL have parameter NCELLS, default 9, number of board cells (addresses 0..NCELLS-1).
REQ-002 SHALL have parameter WR_BURST_MAX, default 3, max consecutive write grants while a read is pending.
REQ-003 SHALL have ph1 input, width 1, phase-1 clock; all state updates on rising ph1.
REQ-004 SHALL have ph2 input, width 1, phase-2 clock; it is present for interface uniformity and drives no logic.
REQ-005 SHALL have reset input, width 1: reset, synchronous, active-low.
REQ-006 SHALL have these write-request inputs: wrReq (1), wrAddr (4), wrData (2, cellStateType), from gameController.
REQ-007 SHALL have these check-read-request inputs: chkReq (1), chkAddr (4), from the win checker.
REQ-008 SHALL have these display-read-request inputs: dispReq (1), dispAddr (4), from display refresh.
REQ-009 SHALL have these clear-request inputs: clrReq (1), a pulse or level that starts a board wipe.
REQ-010 SHALL have these grant outputs, each width 1, each a one-cycle pulse: wrGrant, chkGrant, dispGrant.
REQ-011 SHALL have these read-return outputs: rdData (2), chkValid (1), dispValid (1).
REQ-012 SHALL have these status outputs: clrDone (1, pulse), addrErr (1, pulse concurrent with the offending grant), busy (1, high in CLEAR).
REQ-013 SHALL have these board-port outputs: memAddr (4), memWe (1), memWdata (2).
REQ-014 SHALL have board-port input memRdata (2), the asynchronous read of memAddr.

Function
REQ-015 SHALL implement FSM states IDLE and CLEAR.
REQ-016 SHALL transition IDLE->CLEAR on clrReq=1; clrReq has priority over all other requests.
REQ-017 SHALL, in CLEAR, drive memWe=1, memWdata=EMPTY (00), memAddr 0..NCELLS-1, one address per cycle, with no grants.
REQ-018 SHALL, after the cycle with memAddr=NCELLS-1, pulse clrDone for one cycle and return to IDLE.
REQ-019 SHALL ignore clrReq while in CLEAR; no sweep restart.
REQ-020 SHALL, in IDLE, decide arbitration from inputs sampled at rising ph1, with grant and memory controls registered, asserted in the next cycle for exactly one cycle.
REQ-021 SHALL use write-first priority over reads, except when wrStreak=WR_BURST_MAX and any read is pending, in which case the read wins.
REQ-022 SHALL arbitrate between chkReq and dispReq round-robin: the pointer flips after each read grant and starts at chk after reset.
REQ-023 SHALL count wrStreak as consecutive write grants: saturating at WR_BURST_MAX, cleared on any read grant, and cleared when a cycle grants nothing.
REQ-024 SHALL, on a write grant, set memWe=1, memAddr=wrAddr, memWdata=wrData for that grant cycle only.
REQ-025 SHALL, on a read grant, set memWe=0, memAddr=req address; rdData<=memRdata with chkValid or dispValid high one cycle after the grant.
REQ-026 SHALL ignore a requester's req in the cycle its grant is high, so one request earns one grant and there is no double grant.
REQ-027 SHALL require requesters to hold req and address stable until grant; the arbiter does not latch requests.
REQ-028 SHALL treat any address >= NCELLS as invalid: the grant is still issued with addrErr=1, memWe=0, memAddr=0, and no valid pulse.
REQ-029 SHALL, with no grant, hold memWe=0 and memAddr/memWdata at their previous values.

Reset
REQ-030 SHALL, on reset=0 at rising ph1, force state=IDLE, all grants/valids/clrDone/addrErr/busy=0, memWe=0, memAddr=0, memWdata=00, rdData=00, wrStreak=0, rr pointer=chk.
REQ-031 SHALL, on reset mid-CLEAR, abort the sweep without clrDone; remaining cells are left unwritten.

Structure
REQ-032 SHALL place cellStateType (EMPTY=00, X=10, O=11), NCELLS default, and the arbState enum {IDLE, CLEAR} in shared package tictactoe_pkg.
REQ-033 SHALL contain sub-module board_clear_seq (address counter plus done pulse); arbitration stays in the top level.

Verification
REQ-034 SHALL verify: reset=0 for 2 cycles with all reqs high -> all grants 0, memWe 0, busy 0.
REQ-035 SHALL verify: wrReq, wrAddr=4, wrData=10 alone -> next cycle wrGrant=1, memWe=1, memAddr=4, memWdata=10, then memWe=0.
REQ-036 SHALL verify: chkReq and dispReq held continuously -> grants chk,disp,chk,disp; each valid 1 cycle after its grant; rdData matches the board.
REQ-037 SHALL verify: wrReq held with chkReq pending -> grant order wr,wr,wr,chk,wr.
REQ-038 SHALL verify: clrReq -> busy for 9 cycles, memAddr 0..8, memWdata 00, then clrDone pulse; a wrReq held meanwhile is granted the cycle after clrDone.
REQ-039 SHALL verify: wrAddr=9 -> wrGrant=1, addrErr=1, memWe=0; and reset at sweep address 5 -> IDLE next cycle, no clrDone.
